// File: rtl/i2c_slave_ctrl.sv
// I2C target byte engine: filtered SCL/SDA, START/STOP detect, 7-bit address match.
// Optional SCL clock stretching is compiled in with `define I2C_SLAVE_STRETCH_EN.
module i2c_slave_ctrl #(
    parameter int FILTER_DIV = 4,
    parameter int ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [ADDR_W-1:0] slave_addr,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              scl_o,
    output logic              scl_oen,
    output logic              sda_o,
    output logic              sda_oen,
    output logic              busy,
    output logic              sel,
    output logic              rw,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_nack,
    input  logic [7:0]        tx_data,
    output logic              tx_req,
    input  logic              tx_valid
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] WR_DATA   = 3'd3;
    localparam logic [2:0] WR_ACK    = 3'd4;
    localparam logic [2:0] RD_DATA   = 3'd5;
    localparam logic [2:0] RD_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    localparam logic [15:0] DIV_M1 = 16'(FILTER_DIV - 1);

    function automatic logic maj3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

    logic [1:0]  scl_sync_q, sda_sync_q;
    logic [2:0]  scl_hist_q, sda_hist_q;
    logic [15:0] fcnt_q;
    logic        sscl_q, ssda_q, dscl_q, dsda_q;

    logic        rise_c, fall_c, start_c, stop_c, match_c;
    logic        want_c, load_c;

    logic [2:0]  state_q, state_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  sr_q, sr_d;
    logic        done_q, done_d;
    logic        sda_oen_q, sda_oen_d;
    logic        busy_q, busy_d;
    logic        sel_q, sel_d;
    logic        rw_q, rw_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_go_q, rx_go_d;
    logic        nack_q, nack_d;
    logic        mack_q, mack_d;
    logic        pend_w;

`ifdef I2C_SLAVE_STRETCH_EN
    logic        scl_oen_q, scl_oen_d;
    logic        tx_pend_q, tx_pend_d;
    logic        rel_q, rel_d;
    logic [15:0] rel_cnt_q, rel_cnt_d;
    assign scl_oen = scl_oen_q;
    assign pend_w  = tx_pend_q;
`else
    logic unused_tx_valid;
    assign unused_tx_valid = tx_valid;
    assign scl_oen = 1'b1;
    assign pend_w  = 1'b0;
`endif

    assign scl_o    = 1'b0;
    assign sda_o    = 1'b0;
    assign sda_oen  = sda_oen_q;
    assign busy     = busy_q;
    assign sel      = sel_q;
    assign rw       = rw_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = load_c;

    assign rise_c  = sscl_q & ~dscl_q;
    assign fall_c  = ~sscl_q & dscl_q;
    assign start_c = ~ssda_q & dsda_q & sscl_q;
    assign stop_c  = ssda_q & ~dsda_q & sscl_q;
    assign match_c = (sr_q[7:1] == slave_addr) && (slave_addr != '0);

    // Synchronise pads, decimate into a 3-sample history, majority-vote
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
            fcnt_q     <= '0;
            sscl_q     <= 1'b1;
            ssda_q     <= 1'b1;
            dscl_q     <= 1'b1;
            dsda_q     <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            if (ena) begin
                if (fcnt_q == '0) begin
                    fcnt_q     <= DIV_M1;
                    scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
                    sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
                end else begin
                    fcnt_q <= fcnt_q - 16'd1;
                end
            end
            sscl_q <= maj3(scl_hist_q);
            ssda_q <= maj3(sda_hist_q);
            dscl_q <= sscl_q;
            dsda_q <= ssda_q;
        end
    end

    // Next-state logic: bus conditions first, then per-state bit handling
    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        sr_d       = sr_q;
        done_d     = done_q;
        sda_oen_d  = sda_oen_q;
        busy_d     = busy_q;
        sel_d      = sel_q;
        rw_d       = rw_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_go_d    = 1'b0;
        nack_d     = nack_q;
        mack_d     = mack_q;
        want_c     = 1'b0;
        load_c     = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        scl_oen_d = scl_oen_q;
        tx_pend_d = tx_pend_q;
        rel_d     = rel_q;
        rel_cnt_d = rel_cnt_q;
        if (rel_q) begin
            if (rel_cnt_q == '0) begin
                scl_oen_d = 1'b1;
                rel_d     = 1'b0;
            end else begin
                rel_cnt_d = rel_cnt_q - 16'd1;
            end
        end
`endif
        // A completed byte is delivered even if a bus condition arrives
        if (rx_go_q) begin
            rx_data_d  = sr_q;
            rx_valid_d = 1'b1;
        end
        if (rx_valid_q) nack_d = rx_nack;

        if (!ena || stop_c) begin
            state_d   = IDLE;
            bcnt_d    = '0;
            done_d    = 1'b0;
            sda_oen_d = 1'b1;
            sel_d     = 1'b0;
            busy_d    = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oen_d = 1'b1;
            tx_pend_d = 1'b0;
            rel_d     = 1'b0;
`endif
        end else if (start_c) begin
            state_d   = ADDR;
            bcnt_d    = '0;
            done_d    = 1'b0;
            sda_oen_d = 1'b1;
            sel_d     = 1'b0;
            busy_d    = 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oen_d = 1'b1;
            tx_pend_d = 1'b0;
            rel_d     = 1'b0;
`endif
        end else begin
            case (state_q)
                ADDR: begin
                    if (rise_c) begin
                        sr_d   = {sr_q[6:0], ssda_q};
                        bcnt_d = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) done_d = 1'b1;
                    end else if (fall_c && done_q) begin
                        done_d = 1'b0;
                        bcnt_d = '0;
                        if (match_c) begin
                            state_d   = ADDR_ACK;
                            sda_oen_d = 1'b0;
                            sel_d     = 1'b1;
                            rw_d      = sr_q[0];
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (fall_c) begin
                        if (rw_q) begin
                            want_c = 1'b1;
                        end else begin
                            state_d   = WR_DATA;
                            sda_oen_d = 1'b1;
                            bcnt_d    = '0;
                        end
                    end
                end
                WR_DATA: begin
                    if (rise_c) begin
                        sr_d   = {sr_q[6:0], ssda_q};
                        bcnt_d = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
                            done_d  = 1'b1;
                            rx_go_d = 1'b1;
                        end
                    end else if (fall_c && done_q) begin
                        done_d    = 1'b0;
                        bcnt_d    = '0;
                        state_d   = WR_ACK;
                        sda_oen_d = nack_q;
`ifdef I2C_SLAVE_STRETCH_EN
                        scl_oen_d = 1'b0;
                        rel_d     = 1'b1;
                        rel_cnt_d = '0;
`endif
                    end
                end
                WR_ACK: begin
                    if (fall_c) begin
                        sda_oen_d = 1'b1;
                        bcnt_d    = '0;
                        state_d   = nack_q ? WAIT_STOP : WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (fall_c && !pend_w) begin
                        if (bcnt_q == 3'd7) begin
                            state_d   = RD_ACK;
                            sda_oen_d = 1'b1;
                        end else begin
                            bcnt_d    = bcnt_q + 3'd1;
                            sr_d      = {sr_q[6:0], 1'b1};
                            sda_oen_d = sr_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (rise_c) begin
                        mack_d = ssda_q;
                    end else if (fall_c) begin
                        if (mack_q) state_d = WAIT_STOP;
                        else        want_c  = 1'b1;
                    end
                end
                default: ;
            endcase
`ifdef I2C_SLAVE_STRETCH_EN
            if (want_c) begin
                if (tx_valid) begin
                    load_c = 1'b1;
                end else begin
                    scl_oen_d = 1'b0;
                    tx_pend_d = 1'b1;
                    sda_oen_d = 1'b1;
                    bcnt_d    = '0;
                    state_d   = RD_DATA;
                end
            end
            if (tx_pend_q && tx_valid && state_q == RD_DATA) begin
                load_c    = 1'b1;
                tx_pend_d = 1'b0;
                rel_d     = 1'b1;
                rel_cnt_d = DIV_M1;
            end
`else
            load_c = want_c;
`endif
            if (load_c) begin
                sr_d      = tx_data;
                sda_oen_d = tx_data[7];
                bcnt_d    = '0;
                state_d   = RD_DATA;
            end
        end
    end

    // Protocol state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bcnt_q     <= '0;
            sr_q       <= '0;
            done_q     <= 1'b0;
            sda_oen_q  <= 1'b1;
            busy_q     <= 1'b0;
            sel_q      <= 1'b0;
            rw_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_go_q    <= 1'b0;
            nack_q     <= 1'b0;
            mack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            sr_q       <= sr_d;
            done_q     <= done_d;
            sda_oen_q  <= sda_oen_d;
            busy_q     <= busy_d;
            sel_q      <= sel_d;
            rw_q       <= rw_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_go_q    <= rx_go_d;
            nack_q     <= nack_d;
            mack_q     <= mack_d;
        end
    end

`ifdef I2C_SLAVE_STRETCH_EN
    // Clock-stretch registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_oen_q <= 1'b1;
            tx_pend_q <= 1'b0;
            rel_q     <= 1'b0;
            rel_cnt_q <= '0;
        end else begin
            scl_oen_q <= scl_oen_d;
            tx_pend_q <= tx_pend_d;
            rel_q     <= rel_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end
`endif

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
- I2C target (slave) byte engine; the responder counterpart of the team's master bit controller.
- Filters and synchronises SCL/SDA, detects START/STOP, and matches a 7-bit address.
- Shifts write data in and presents whole bytes to the host; shifts read data out from the host.
- Drives ACK/NACK and, optionally, clock stretching; sits between the pad open-drain buffers and a register-file host interface.

Parameters:
- FILTER_DIV, 4: clk cycles between filter samples (1..65535); FILTER_DIV=1 means sample every cycle.
- ADDR_W, 7: target address width; only 7 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ena  in  1  block enable; 0 = release bus, return to IDLE, hold filter counter
- slave_addr  in  7  own address, compared against the received address bits [7:1]
- scl_i  in  1  SCL pad input
- sda_i  in  1  SDA pad input
- scl_o  out  1  constant 0
- scl_oen  out  1  SCL output enable, active low (0 pulls the line low)
- sda_o  out  1  constant 0
- sda_oen  out  1  SDA output enable, active low
- busy  out  1  bus busy: set on START, cleared on STOP
- sel  out  1  addressed: high from address ACK until STOP or repeated START
- rw  out  1  R/W bit of the last matched address byte (1 = read)
- rx_data  out  8  last received write byte
- rx_valid  out  1  one-cycle strobe, rx_data is new
- rx_nack  in  1  sampled at the rx_valid cycle; 1 = NACK this byte
- tx_data  in  8  next read byte
- tx_req  out  1  one-cycle strobe, tx_data is sampled in this cycle
- tx_valid  in  1  used only with the stretch feature

Behaviour:
- Reset values (rst asserted): scl_oen=1, sda_oen=1, busy=0, sel=0, rw=0, rx_data=0, rx_valid=0, tx_req=0; state=IDLE; filter history = all 1s.

Input filtering:
- scl_i and sda_i pass through a 2-flop synchroniser.
- Every FILTER_DIV cycles the synchronised value is shifted into a 3-bit history.
- sSCL/sSDA are the 2-of-3 majority of that history, registered.
- dSCL/dSDA are sSCL/sSDA delayed one cycle.

Bus conditions:
- SCL rise = sSCL & ~dSCL; SCL fall = ~sSCL & dSCL.
- START = ~sSDA & dSDA & sSCL; STOP = sSDA & ~dSDA & sSCL.
- START or STOP, in any state, overrides everything else and takes effect the following cycle:
  - START -> ADDR with bit counter cleared, sda_oen=1, sel=0.
  - STOP -> IDLE with sda_oen=1, sel=0.

Bit timing:
- SDA is sampled on SCL rise.
- The block changes sda_oen only on SCL fall.
- MSB first; 3-bit counter, a byte completes on the 8th rise.

State machine:
- IDLE: wait for START.
- ADDR: shift 8 bits. At the 8th-bit SCL fall:
  - match -> ADDR_ACK, sda_oen=0, sel=1, rw latched;
  - no match -> WAIT_STOP.
- ADDR_ACK: at SCL fall after the ACK clock:
  - rw=0 -> WR_DATA, sda_oen=1;
  - rw=1 -> load the tx byte (tx_req strobe), drive bit7, go to RD_DATA.
- WR_DATA: after the 8th rise, rx_data/rx_valid update the next cycle. At the following SCL fall -> WR_ACK with sda_oen=rx_nack.
- WR_ACK: at SCL fall -> WR_DATA, sda_oen=1. If the ACK was a NACK -> WAIT_STOP instead.
- RD_DATA: drive bits on each fall. After the 8th bit's fall -> RD_ACK, sda_oen=1.
- RD_ACK: sample the master ACK on rise.
  - ACK (0) -> at fall, load the next byte and go to RD_DATA.
  - NACK (1) -> WAIT_STOP.
- WAIT_STOP: bus released; only START/STOP are honoured.

Other rules:
- General call (address 0) is not matched.
- scl_oen stays 1 at all times unless the stretch feature is compiled in.
- ena=0 gives the same effect as STOP, immediately.
- rst mid-transfer releases both lines asynchronously.
- Simultaneous rx_valid and START: the byte is still delivered, and the state goes to ADDR.

Optional Feature:
- Macro: I2C_SLAVE_STRETCH_EN.
- Defined, read path:
  - at a tx load point where tx_valid=0, the block holds scl_oen=0 from the SCL fall until tx_valid=1;
  - then it samples tx_data (tx_req strobe), drives bit7, waits 1 filter period and releases scl_oen.
- Defined, write path: scl_oen is also held low after the 8th write bit until the host accepts the byte (rx_valid strobe) and the cycle after.
- Undefined: scl_oen is constant 1, and tx_valid is ignored.

Test Plan:
- slave_addr=7'h42; master writes START, 0x84, 0xA5, 0x3C, STOP -> address ACK; rx_valid twice with 0xA5 then 0x3C; both ACKed; sel rises then falls at STOP; busy 1 then 0.
- Master START, 0x86 (addr 0x43) with slave_addr=7'h42 -> sda_oen stays 1 throughout; sel=0; state WAIT_STOP until STOP.
- Read: START, 0x85; tx_data=0x96 then 0x5A; master ACK then NACK, STOP -> SDA carries 1001_0110 then 0101_1010; tx_req pulses twice; after NACK the line is released.
- Write with rx_nack=1 on the first byte 0x11 -> sda_oen=1 during the ACK clock; later bytes ignored until STOP.
- Repeated START mid-write (0x84, 0x01, Sr, 0x85) -> rx_valid for 0x01, then read phase with rw=1; busy stays 1.
- rst pulsed while sda_oen=0 during ACK -> sda_oen=1 within the same cycle, state IDLE; with STRETCH_EN and tx_valid=0 for 50 clks -> SCL held low 50+ clks, then 0x96 transmitted correctly.
